// File: rtl/fmr_lane_driver.sv
// Replicates one data bit onto the five 5MR voter lanes, with per-lane fault injection and a self-timed 32-pattern sweep.
// One-cycle registered latency; d_ready only drops while a sweep owns the lanes, and the voter never stalls us.
module fmr_lane_driver #(
  parameter int HOLD_CYCLES = 30,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [4:0]       inj_mask,
  input  logic [1:0]       inj_type,
  input  logic             mode_sweep,
  input  logic             start,
  output logic [4:0]       x_out,
  output logic             x_valid,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] words_sent
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       pattern, pattern_nxt;
  logic [HW-1:0]    hold, hold_nxt;
  logic [4:0]       x_nxt;
  logic             xv_nxt, busy_nxt, done_nxt;
  logic [CNT_W-1:0] ws_nxt;
  logic             go, xfer;

  function automatic logic [4:0] inject(input logic d, input logic [4:0] m, input logic [1:0] t);
    logic [4:0] r;
    r = {5{d}};
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        case (t)
          2'b01:   r[i] = !d;
          2'b10:   r[i] = 1'b0;
          2'b11:   r[i] = 1'b1;
          default: r[i] = d;
        endcase
      end
    end
    return r;
  endfunction

  assign d_ready = !sweep_busy && !rst;
  // A sweep launch takes priority over a coincident data beat.
  assign go      = (state == IDLE) && start && mode_sweep;
  assign xfer    = d_valid && d_ready && !go && (state != SWEEP);

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    hold_nxt    = hold;
    x_nxt       = x_out;
    xv_nxt      = 1'b0;
    busy_nxt    = sweep_busy;
    done_nxt    = 1'b0;
    ws_nxt      = words_sent;

    if (xfer) begin
      x_nxt  = inject(d_in, inj_mask, inj_type);
      xv_nxt = 1'b1;
      if (words_sent != {CNT_W{1'b1}}) ws_nxt = words_sent + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (go) begin
          state_nxt   = SWEEP;
          pattern_nxt = 5'd0;
          hold_nxt    = '0;
          x_nxt       = 5'd0;
          xv_nxt      = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      SWEEP: begin
        xv_nxt = 1'b1;
        if (hold == HOLD_MAX) begin
          hold_nxt = '0;
          if (pattern == 5'd31) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            xv_nxt    = 1'b0;
          end else begin
            pattern_nxt = pattern + 5'd1;
            x_nxt       = pattern + 5'd1;
          end
        end else begin
          hold_nxt = hold + HW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pattern    <= 5'd0;
      hold       <= '0;
      x_out      <= 5'd0;
      x_valid    <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      hold       <= hold_nxt;
      x_out      <= x_nxt;
      x_valid    <= xv_nxt;
      sweep_busy <= busy_nxt;
      sweep_done <= done_nxt;
      words_sent <= ws_nxt;
    end
  end

endmodule

// File: tb/tb_fmr_lane_driver.sv
// Directed bench for fmr_lane_driver: injection vector table, sweep timing, async reset and counter saturation.
module tb_fmr_lane_driver;

  localparam int HOLD = 30;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_in, d_valid, d_ready;
  logic [4:0]    inj_mask;
  logic [1:0]    inj_type;
  logic          mode_sweep, start;
  logic [4:0]    x_out;
  logic          x_valid, sweep_busy, sweep_done;
  logic [CW-1:0] words_sent;

  int checks = 0;
  int errors = 0;

  fmr_lane_driver #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
    .inj_mask(inj_mask), .inj_type(inj_type), .mode_sweep(mode_sweep), .start(start),
    .x_out(x_out), .x_valid(x_valid), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       d;
    logic       v;
    logic [4:0] m;
    logic [1:0] t;
    logic [4:0] ex;
    logic       exv;
    logic [3:0] ews;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {x_out, x_valid, sweep_busy, sweep_done, d_ready}
  function automatic logic [8:0] snap();
    return {x_out, x_valid, sweep_busy, sweep_done, d_ready};
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'b00000, 2'b00, 5'b11111, 1'b1, 4'd1};
    vecs[1] = '{1'b0, 1'b1, 5'b00000, 2'b00, 5'b00000, 1'b1, 4'd2};
    vecs[2] = '{1'b1, 1'b0, 5'b00000, 2'b00, 5'b00000, 1'b0, 4'd2};
    vecs[3] = '{1'b1, 1'b1, 5'b00011, 2'b01, 5'b11100, 1'b1, 4'd3};
    vecs[4] = '{1'b0, 1'b1, 5'b10101, 2'b11, 5'b10101, 1'b1, 4'd4};
    vecs[5] = '{1'b1, 1'b1, 5'b11100, 2'b10, 5'b00011, 1'b1, 4'd5};
    vecs[6] = '{1'b1, 1'b1, 5'b11111, 2'b00, 5'b11111, 1'b1, 4'd6};
    vecs[7] = '{1'b0, 1'b0, 5'b11111, 2'b01, 5'b11111, 1'b0, 4'd6};
    vecs[8] = '{1'b0, 1'b1, 5'b01010, 2'b01, 5'b01010, 1'b1, 4'd7};
    vecs[9] = '{1'b1, 1'b1, 5'b00001, 2'b11, 5'b11111, 1'b1, 4'd8};

    rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; inj_mask = '0; inj_type = '0;
    mode_sweep = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {23'd0, snap()}, {23'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("reset_words", 32'(words_sent), 32'd0);

    // Manual path vector table
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      d_in = vecs[i].d; d_valid = vecs[i].v; inj_mask = vecs[i].m; inj_type = vecs[i].t;
      @(negedge clk);
      chk($sformatf("vec%0d_x_out", i), 32'(x_out), 32'(vecs[i].ex));
      chk($sformatf("vec%0d_x_valid", i), 32'(x_valid), 32'(vecs[i].exv));
      chk($sformatf("vec%0d_words", i), 32'(words_sent), 32'(vecs[i].ews));
      chk($sformatf("vec%0d_ready", i), 32'(d_ready), 32'd1);
    end
    d_valid = 1'b0; inj_mask = '0; inj_type = '0;

    // Asynchronous reset asserted between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {23'd0, snap()}, 32'd0);
    chk("async_rst_words", 32'(words_sent), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start without mode_sweep: ignored, data accepted
    d_in = 1'b0; d_valid = 1'b1; start = 1'b1; mode_sweep = 1'b0;
    @(negedge clk);
    chk("start_no_mode", {23'd0, snap()}, {23'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("start_no_mode_words", 32'(words_sent), 32'd1);
    start = 1'b0;

    // Full sweep; start coincides with d_valid so the data must be dropped
    d_in = 1'b1; d_valid = 1'b1; start = 1'b1; mode_sweep = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 32 * HOLD; k++) begin
      chk($sformatf("sweep_k%0d", k), {23'd0, snap()}, {23'd0, 5'(k / HOLD), 1'b1, 1'b1, 1'b0, 1'b0});
      start = (k == 100 || k == 500);
      if (k == 32 * HOLD - 1) d_valid = 1'b0;
      @(negedge clk);
    end
    chk("sweep_done_cycle", {23'd0, snap()}, {23'd0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1});
    chk("sweep_words_unchanged", 32'(words_sent), 32'd1);
    @(negedge clk);
    chk("after_done_idle", {23'd0, snap()}, {23'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1});

    // Reset while pattern 13 is on the lanes, then restart from 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13 * HOLD + 5) @(negedge clk);
    chk("mid_sweep_pattern", 32'(x_out), 32'd13);
    #2 rst = 1'b1;
    #1;
    chk("mid_sweep_rst", {23'd0, snap()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {23'd0, snap()}, {23'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_p0", {23'd0, snap()}, {23'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    repeat (HOLD - 1) @(negedge clk);
    chk("restart_p0_last", 32'(x_out), 32'd0);
    @(negedge clk);
    chk("restart_p1", 32'(x_out), 32'd1);

    // Saturation of the 4-bit counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mode_sweep = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d_in = i[0]; d_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("sat%0d_words", i), 32'(words_sent), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk($sformatf("sat%0d_x_out", i), 32'(x_out), i[0] ? 32'h1f : 32'h0);
    end
    d_valid = 1'b0;
    @(negedge clk);
    chk("sat_final", 32'(words_sent), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
